ldpc_llr_loader: RTL and testbench
==================================

Name: ldpc_llr_loader

Overview:
- Frame I/O stage directly upstream of the variable-node array. It owns the llr_access/llr_addr/llr_din_we/llr_din interface of every variable node.
- Load phase: accepts a serial two's-complement channel-LLR stream, converts each sample to sign-magnitude, and scatters it to (vn, addr).
- Unload phase: sweeps the same addresses, collects each node's llr_dout after the pipeline latency, and emits hard-decision bits through a credit-controlled output FIFO.

Parameters:
- FOLDFACTOR, 1, address width is 7+FOLDFACTOR.
- LLRWIDTH, 6, LLR width in bits.
- NUM_VN, 360, number of variable-node instances.
- FRAME_ADDRS, 180, addresses per node per frame (≤ 2^(7+FOLDFACTOR)).
- RD_LATENCY, 5, cycles from llr_addr driven to valid llr_dout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start_load  in  1  pulse: begin load of one frame.
- start_unload  in  1  pulse: begin unload of one frame.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse at end of a load or unload.
- in_valid  in  1  input LLR valid.
- in_ready  out  1  input LLR ready.
- in_llr  in  LLRWIDTH  two's-complement channel LLR.
- llr_access  out  1  to all VNs: I/O mode.
- llr_addr  out  7+FOLDFACTOR  to all VNs: shared address.
- llr_din_we  out  NUM_VN  one-hot write enable, bit v drives VN v.
- llr_din  out  LLRWIDTH  sign-magnitude LLR, broadcast to all VNs.
- llr_dout_bus  in  NUM_VN*LLRWIDTH  concatenated llr_dout; VN v occupies slice [v*LLRWIDTH +: LLRWIDTH].
- out_valid  out  1  hard-decision valid.
- out_ready  in  1  hard-decision ready.
- out_bit  out  1  hard decision.

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; FIFO empty; every output 0.
- FSM states: IDLE, LOAD, UNLOAD, DRAIN.
  - IDLE: start_load → LOAD; else start_unload → UNLOAD. If both are asserted, load wins. Starts in any other state are ignored.
- Scan order (load and unload): vn index v inner 0..NUM_VN-1, address a outer 0..FRAME_ADDRS-1. Sample k maps to v = k mod NUM_VN, a = k / NUM_VN.
- LOAD:
  - in_ready = 1. Each in_valid&in_ready registers one cycle later: llr_din = conv(in_llr), llr_addr = a, llr_din_we = one-hot(v), llr_access = 1.
  - Cycles with no handshake: llr_din_we = 0, counters hold.
  - Accepting the last sample (v = NUM_VN-1, a = FRAME_ADDRS-1) → IDLE. in_ready drops the same cycle.
  - The final write cycle carries llr_access = 1 and done = 1. llr_access = 0 on the next cycle.
- conv(x):
  - sign = x[MSB]; mag = |x|.
  - x = -2^(LLRWIDTH-1) saturates to mag = 2^(LLRWIDTH-1)-1.
  - Output is {sign, mag}. Zero maps to all-zero (positive zero).
- UNLOAD:
  - llr_access = 1, llr_din_we = 0.
  - Issue one read per cycle (llr_addr = a, registered) only when fifo_count + inflight < FIFO_DEPTH, where FIFO_DEPTH = RD_LATENCY+2.
  - The issued v is carried in a RD_LATENCY-deep valid/index shift register.
  - On arrival, write the sign bit of slice v of llr_dout_bus into the FIFO (1 = negative LLR = bit 1).
  - After the last read issues → DRAIN.
- DRAIN: llr_access held 1; → IDLE with done = 1 when inflight = 0 and the FIFO is empty.
- Output side: out_valid = FIFO not empty; out_bit = FIFO head; pop on out_valid&out_ready. FIFO never overflows, by construction of the credit rule.
- FIFO boundaries:
  - Simultaneous push and pop keeps the count.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation aborts immediately: no done pulse; partial frame discarded; next start begins at v = 0, a = 0.
- Counters are sized for FRAME_ADDRS and NUM_VN with no wrap beyond the frame. Bits of llr_addr above the counter width are 0.

Test Plan:
- Conversion, NUM_VN=4, FRAME_ADDRS=3: in_llr 6'b111011 (-5) → llr_din 6'b100101; -32 → 6'b111111; +7 → 6'b000111; 0 → 6'b000000.
- Load order: 12 back-to-back samples k = 0..11 → sample k writes llr_addr = k/4 with llr_din_we bit k%4 only. done and llr_access = 1 on the 12th write; llr_access = 0 on the following cycle; busy low thereafter.
- Input gaps: in_valid low for 3 cycles mid-frame → llr_din_we = 0 in those cycles; no address/vn skipped; exactly 12 writes total.
- Unload with behavioural VN model (latency 5), stored signs known, out_ready low for 20 cycles then high:
  - no more than 7 reads outstanding or buffered;
  - 12 out_bit values emitted in scan order with no loss or duplication;
  - done is asserted once, after the last pop.
- Reset (rst low) after 5 load handshakes → all outputs 0 asynchronously. A new start_load writes its first sample to addr 0 / VN 0.
- start_load and start_unload pulsed in the same cycle in IDLE → LOAD entered (in_ready = 1); start_unload during LOAD has no effect.

Source files
------------

// File: rtl/ldpc_llr_loader_if.sv
// ldpc_llr_loader_if: groups the frame I/O stage's handshake and variable-node bus signals.
//   Control : start_load, start_unload, busy, done
//   Input   : in_valid / in_ready / in_llr (two's-complement channel LLR stream)
//   VN bus  : llr_access, llr_addr, llr_din_we (one-hot per VN), llr_din, llr_dout_bus
//   Output  : out_valid / out_ready / out_bit (hard decisions)
// The master modport is the loader; the slave modport is the surrounding system.
interface ldpc_llr_loader_if #(
    parameter int unsigned FOLDFACTOR = 1,
    parameter int unsigned LLRWIDTH   = 6,
    parameter int unsigned NUM_VN     = 360
);
    logic                         start_load;
    logic                         start_unload;
    logic                         busy;
    logic                         done;
    logic                         in_valid;
    logic                         in_ready;
    logic [LLRWIDTH-1:0]          in_llr;
    logic                         llr_access;
    logic [7+FOLDFACTOR-1:0]      llr_addr;
    logic [NUM_VN-1:0]            llr_din_we;
    logic [LLRWIDTH-1:0]          llr_din;
    logic [NUM_VN*LLRWIDTH-1:0]   llr_dout_bus;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_bit;

    modport master (
        input  start_load, start_unload, in_valid, in_llr, llr_dout_bus, out_ready,
        output busy, done, in_ready, llr_access, llr_addr, llr_din_we, llr_din,
               out_valid, out_bit
    );

    modport slave (
        output start_load, start_unload, in_valid, in_llr, llr_dout_bus, out_ready,
        input  busy, done, in_ready, llr_access, llr_addr, llr_din_we, llr_din,
               out_valid, out_bit
    );
endinterface

// File: rtl/ldpc_llr_loader.sv
// ldpc_llr_loader: frame I/O stage in front of the variable-node array.
//   Load   : accepts a serial two's-complement LLR stream, converts each sample to
//            sign-magnitude and writes it to VN v = k mod NUM_VN at address a = k / NUM_VN.
//   Unload : sweeps the same addresses, picks each VN's llr_dout after RD_LATENCY cycles and
//            pushes its sign (hard decision) into a small credit-controlled output FIFO.
// Ports: clk, rst (async, active-low) and bus (ldpc_llr_loader_if.master).
module ldpc_llr_loader #(
    parameter int unsigned FOLDFACTOR  = 1,
    parameter int unsigned LLRWIDTH    = 6,
    parameter int unsigned NUM_VN      = 360,
    parameter int unsigned FRAME_ADDRS = 180,
    parameter int unsigned RD_LATENCY  = 5
) (
    input logic               clk,
    input logic               rst,
    ldpc_llr_loader_if.master bus
);
    localparam int unsigned AW         = 7 + FOLDFACTOR;
    localparam int unsigned VW         = (NUM_VN > 1) ? $clog2(NUM_VN) : 1;
    localparam int unsigned CW         = (FRAME_ADDRS > 1) ? $clog2(FRAME_ADDRS) : 1;
    localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam int unsigned NW         = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StUnload, StDrain} state_e;

    state_e                         state_q, state_d;
    logic [VW-1:0]                  v_q, v_d;
    logic [CW-1:0]                  a_q, a_d;
    logic                           access_q, access_d;
    logic [AW-1:0]                  addr_q, addr_d;
    logic [NUM_VN-1:0]              we_q, we_d;
    logic [LLRWIDTH-1:0]            din_q, din_d;
    logic                           done_q, done_d;
    // Read issued this cycle (travels with llr_addr), then RD_LATENCY more stages until
    // the VN data is valid on llr_dout_bus.
    logic                           iss_vld_q, iss_vld_d;
    logic [VW-1:0]                  iss_idx_q, iss_idx_d;
    logic [RD_LATENCY-1:0]          sr_vld_q, sr_vld_d;
    logic [RD_LATENCY-1:0][VW-1:0]  sr_idx_q, sr_idx_d;
    logic [NW-1:0]                  inflight_q, inflight_d;
    logic [FIFO_DEPTH-1:0]          fifo_mem_q, fifo_mem_d;
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]                  fifo_cnt_q, fifo_cnt_d;

    logic [NUM_VN-1:0] sign_bits;
    logic              last_v, last_a, issue, push, pop, push_bit;

    for (genvar g = 0; g < NUM_VN; g++) begin : g_sign
        assign sign_bits[g] = bus.llr_dout_bus[g*LLRWIDTH + LLRWIDTH - 1];
    end

    // Two's complement to sign-magnitude; the most negative code saturates.
    function automatic logic [LLRWIDTH-1:0] conv(input logic [LLRWIDTH-1:0] x);
        logic [LLRWIDTH-1:0] neg;
        logic [LLRWIDTH-2:0] mag;
        neg = -x;
        if (!x[LLRWIDTH-1])                                  mag = x[LLRWIDTH-2:0];
        else if (x == {1'b1, {(LLRWIDTH-1){1'b0}}})          mag = '1;
        else                                                 mag = neg[LLRWIDTH-2:0];
        return {x[LLRWIDTH-1], mag};
    endfunction

    assign last_v   = (v_q == VW'(NUM_VN - 1));
    assign last_a   = (a_q == CW'(FRAME_ADDRS - 1));
    // Credit rule: everything issued but not yet popped must fit in the FIFO.
    assign issue    = (state_q == StUnload) &&
                      ((int'(fifo_cnt_q) + int'(inflight_q)) < int'(FIFO_DEPTH));
    assign push     = sr_vld_q[RD_LATENCY-1];
    assign push_bit = sign_bits[sr_idx_q[RD_LATENCY-1]];
    assign pop      = (fifo_cnt_q != '0) && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        a_d       = a_q;
        addr_d    = addr_q;
        we_d      = '0;
        din_d     = din_q;
        done_d    = 1'b0;
        access_d  = (state_q != StIdle);
        iss_vld_d = 1'b0;
        iss_idx_d = iss_idx_q;

        unique case (state_q)
            StIdle: begin
                v_d = '0;
                a_d = '0;
                if (bus.start_load)        state_d = StLoad;
                else if (bus.start_unload) state_d = StUnload;
            end
            StLoad: begin
                if (bus.in_valid) begin
                    din_d     = conv(bus.in_llr);
                    addr_d    = AW'(a_q);
                    we_d[v_q] = 1'b1;
                    if (last_v) begin
                        v_d = '0;
                        a_d = a_q + CW'(1);
                    end else begin
                        v_d = v_q + VW'(1);
                    end
                    if (last_v && last_a) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        a_d     = '0;
                    end
                end
            end
            StUnload: begin
                if (issue) begin
                    addr_d    = AW'(a_q);
                    iss_vld_d = 1'b1;
                    iss_idx_d = v_q;
                    if (last_v) begin
                        v_d = '0;
                        a_d = a_q + CW'(1);
                    end else begin
                        v_d = v_q + VW'(1);
                    end
                    if (last_v && last_a) begin
                        state_d = StDrain;
                        a_d     = '0;
                    end
                end
            end
            StDrain: begin
                if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sr_vld_d    = sr_vld_q;
        sr_idx_d    = sr_idx_q;
        sr_vld_d[0] = iss_vld_q;
        sr_idx_d[0] = iss_idx_q;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            sr_vld_d[i] = sr_vld_q[i-1];
            sr_idx_d[i] = sr_idx_q[i-1];
        end

        inflight_d = inflight_q;
        if (issue && !push)      inflight_d = inflight_q + NW'(1);
        else if (!issue && push) inflight_d = inflight_q - NW'(1);

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_bit;
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + NW'(1);
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - NW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            v_q        <= '0;
            a_q        <= '0;
            access_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= '0;
            din_q      <= '0;
            done_q     <= 1'b0;
            iss_vld_q  <= 1'b0;
            iss_idx_q  <= '0;
            sr_vld_q   <= '0;
            sr_idx_q   <= '0;
            inflight_q <= '0;
            fifo_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            a_q        <= a_d;
            access_q   <= access_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            din_q      <= din_d;
            done_q     <= done_d;
            iss_vld_q  <= iss_vld_d;
            iss_idx_q  <= iss_idx_d;
            sr_vld_q   <= sr_vld_d;
            sr_idx_q   <= sr_idx_d;
            inflight_q <= inflight_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.in_ready   = (state_q == StLoad);
    assign bus.llr_access = access_q;
    assign bus.llr_addr   = addr_q;
    assign bus.llr_din_we = we_q;
    assign bus.llr_din    = din_q;
    assign bus.out_valid  = (fifo_cnt_q != '0);
    assign bus.out_bit    = fifo_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_ldpc_llr_loader.sv
// Directed bench for ldpc_llr_loader with NUM_VN=4, FRAME_ADDRS=3 and a behavioural
// variable-node array of read latency 5.
module tb_ldpc_llr_loader;
    localparam int unsigned NV = 4;
    localparam int unsigned NA = 3;
    localparam int unsigned LW = 6;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    ldpc_llr_loader_if #(.FOLDFACTOR(1), .LLRWIDTH(LW), .NUM_VN(NV)) bus_if ();

    ldpc_llr_loader #(
        .FOLDFACTOR (1),
        .LLRWIDTH   (LW),
        .NUM_VN     (NV),
        .FRAME_ADDRS(NA),
        .RD_LATENCY (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural VN array: write on llr_din_we, read data 5 cycles after llr_addr.
    logic [LW-1:0] vn_mem [NV][NA];
    logic [7:0]    rd_pipe [5];

    always @(posedge clk) begin
        for (int i = 4; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= bus_if.llr_addr;
        if (bus_if.llr_access) begin
            for (int v = 0; v < int'(NV); v++) begin
                if (bus_if.llr_din_we[v] && bus_if.llr_addr < 8'(NA))
                    vn_mem[v][bus_if.llr_addr[1:0]] <= bus_if.llr_din;
            end
        end
    end

    always_comb begin
        bus_if.llr_dout_bus = '0;
        for (int v = 0; v < int'(NV); v++) begin
            if (rd_pipe[4] < 8'(NA)) bus_if.llr_dout_bus[v*LW +: LW] = vn_mem[v][rd_pipe[4][1:0]];
        end
    end

    // Hand-computed stimulus and sign-magnitude images.
    logic [LW-1:0] in_tab [12] = '{6'b111011, 6'b100000, 6'b000111, 6'b000000,
                                   6'b011111, 6'b111111, 6'b000001, 6'b100001,
                                   6'b001100, 6'b110100, 6'b111110, 6'b000101};
    logic [LW-1:0] cv_tab [12] = '{6'b100101, 6'b111111, 6'b000111, 6'b000000,
                                   6'b011111, 6'b100001, 6'b000001, 6'b111111,
                                   6'b001100, 6'b101100, 6'b100010, 6'b000101};
    logic          sg_tab [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(bus_if.busy),       32'd0);
        check({tag, "_done"},   32'(bus_if.done),       32'd0);
        check({tag, "_rdy"},    32'(bus_if.in_ready),   32'd0);
        check({tag, "_access"}, 32'(bus_if.llr_access), 32'd0);
        check({tag, "_addr"},   32'(bus_if.llr_addr),   32'd0);
        check({tag, "_we"},     32'(bus_if.llr_din_we), 32'd0);
        check({tag, "_din"},    32'(bus_if.llr_din),    32'd0);
        check({tag, "_ovld"},   32'(bus_if.out_valid),  32'd0);
        check({tag, "_obit"},   32'(bus_if.out_bit),    32'd0);
    endtask

    initial begin
        int n_out;
        int n_done;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus_if.start_load   = 1'b0;
        bus_if.start_unload = 1'b0;
        bus_if.in_valid     = 1'b0;
        bus_if.in_llr       = '0;
        bus_if.out_ready    = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Both starts together: load must win.
        bus_if.start_load   = 1'b1;
        bus_if.start_unload = 1'b1;
        @(posedge clk); #1;
        bus_if.start_load   = 1'b0;
        bus_if.start_unload = 1'b0;
        check("prio_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("prio_busy",     32'(bus_if.busy),     32'd1);

        for (int k = 0; k < 12; k++) begin
            if (k == 6) begin
                bus_if.in_valid = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("gap_we",  32'(bus_if.llr_din_we), 32'd0);
                    check("gap_rdy", 32'(bus_if.in_ready),   32'd1);
                end
            end
            bus_if.in_valid     = 1'b1;
            bus_if.in_llr       = in_tab[k];
            bus_if.start_unload = (k == 3);
            @(posedge clk); #1;
            bus_if.start_unload = 1'b0;
            check("load_addr",   32'(bus_if.llr_addr),   32'(k / 4));
            check("load_we",     32'(bus_if.llr_din_we), 32'(1 << (k % 4)));
            check("load_din",    32'(bus_if.llr_din),    32'(cv_tab[k]));
            check("load_access", 32'(bus_if.llr_access), 32'd1);
            check("load_done",   32'(bus_if.done),       32'(k == 11));
        end
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_access", 32'(bus_if.llr_access), 32'd0);
        check("post_done",   32'(bus_if.done),       32'd0);
        check("post_busy",   32'(bus_if.busy),       32'd0);
        check("post_rdy",    32'(bus_if.in_ready),   32'd0);
        @(posedge clk); #1;
        check("post_busy2",  32'(bus_if.busy),       32'd0);

        // Unload with the output stalled: reads stop once 7 are outstanding/buffered.
        bus_if.start_unload = 1'b1;
        @(posedge clk); #1;
        bus_if.start_unload = 1'b0;
        check("unl_busy", 32'(bus_if.busy),     32'd1);
        check("unl_rdy",  32'(bus_if.in_ready), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_addr",   32'(bus_if.llr_addr),   32'd1);
        check("stall_ovld",   32'(bus_if.out_valid),  32'd1);
        check("stall_access", 32'(bus_if.llr_access), 32'd1);
        check("stall_we",     32'(bus_if.llr_din_we), 32'd0);

        bus_if.out_ready = 1'b1;
        n_out  = 0;
        n_done = 0;
        for (int c = 0; c < 300 && !(n_out >= 12 && n_done > 0); c++) begin
            @(negedge clk);
            if (bus_if.done) begin
                n_done++;
                check("done_after_last_pop", 32'(n_out), 32'd12);
            end
            if (bus_if.out_valid) begin
                if (n_out < 12) check("out_bit", 32'(bus_if.out_bit), 32'(sg_tab[n_out]));
                else            check("out_extra", 32'(n_out), 32'd11);
                n_out++;
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (bus_if.done) n_done++;
            if (bus_if.out_valid) n_out++;
        end
        check("out_count",  32'(n_out),            32'd12);
        check("done_count", 32'(n_done),           32'd1);
        check("unl_idle",   32'(bus_if.busy),      32'd0);
        check("unl_access", 32'(bus_if.llr_access), 32'd0);

        // Reset in the middle of a load, then restart from VN 0 / address 0.
        @(posedge clk); #1;
        bus_if.start_load = 1'b1;
        @(posedge clk); #1;
        bus_if.start_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_llr   = in_tab[k];
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        check("pre_rst_addr", 32'(bus_if.llr_addr), 32'd1);
        check("pre_rst_din",  32'(bus_if.llr_din),  32'(cv_tab[4]));
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus_if.start_load = 1'b1;
        @(posedge clk); #1;
        bus_if.start_load = 1'b0;
        bus_if.in_valid   = 1'b1;
        bus_if.in_llr     = 6'b001001;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        check("restart_addr", 32'(bus_if.llr_addr),   32'd0);
        check("restart_we",   32'(bus_if.llr_din_we), 32'd1);
        check("restart_din",  32'(bus_if.llr_din),    32'h09);
        check("restart_done", 32'(bus_if.done),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
